// File: rtl/bos_spi_slave.sv
// SPI slave (CPOL=1, CPHA=1) with a 24-bit R/W frame and a 14-bit register file.
// All SPI pins are resynchronised into clk; the frame is decoded from synchronised edges.
module bos_spi_slave #(
    parameter int          N_REGS   = 8,
    parameter logic [13:0] REG_INIT = 14'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sck,
    input  logic                   sdatai,
    input  logic                   n_cs,
    output logic                   sdatao,
    output logic [14*N_REGS-1:0]   regs,
    output logic                   wr_stb,
    output logic [6:0]             wr_addr,
    output logic [13:0]            wr_data,
    output logic                   frame_err,
    output logic                   busy
);

    // state | meaning
    // IDLE  | no frame, waiting for n_cs falling edge
    // CMD   | shifting in R/W + address (bits 1..8)
    // DATA  | shifting data in, read data out (bits 9..24)
    // HOLD  | 24 bits received, ignoring sck until n_cs rises
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [7:0] LP_NREGS = 8'(N_REGS);

    logic        r_sck_m, r_sck_s, r_sck_d;
    logic        r_cs_m, r_cs_s, r_cs_d;
    logic        r_sdi_m, r_sdi_s;
    logic [1:0]  r_flush;
    logic        r_armed;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [12:0] r_shift;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic [15:0] r_tx;
    logic        r_sdo;
    logic [13:0] r_regs [N_REGS];

    logic        w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_sample;
    logic [13:0] w_shift_nxt;
    logic [13:0] w_rd_data;
    logic        w_addr_ok;
    logic        w_commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_m <= 1'b1;
            r_sck_s <= 1'b1;
            r_sck_d <= 1'b1;
            r_cs_m  <= 1'b1;
            r_cs_s  <= 1'b1;
            r_cs_d  <= 1'b1;
            r_sdi_m <= 1'b0;
            r_sdi_s <= 1'b0;
        end else begin
            r_sck_m <= sck;
            r_sck_s <= r_sck_m;
            r_sck_d <= r_sck_s;
            r_cs_m  <= n_cs;
            r_cs_s  <= r_cs_m;
            r_cs_d  <= r_cs_s;
            r_sdi_m <= sdatai;
            r_sdi_s <= r_sdi_m;
        end
    end

    // After reset the synchronisers hold idle levels; wait until they carry the real
    // n_cs and it has been seen high, so a chip select held low across reset is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            if (r_flush != 2'd3)
                r_flush <= r_flush + 2'd1;
            r_armed <= (r_flush == 2'd3) && (r_armed || r_cs_s);
        end
    end

    assign w_sck_rise  = r_sck_s & ~r_sck_d;
    assign w_sck_fall  = ~r_sck_s & r_sck_d;
    assign w_cs_fall   = ~r_cs_s & r_cs_d & r_armed;
    assign w_cs_rise   = r_cs_s & ~r_cs_d;
    assign w_sample    = w_sck_rise & ~r_cs_s;
    assign w_shift_nxt = {r_shift, r_sdi_s};
    assign w_addr_ok   = ({1'b0, r_addr} < LP_NREGS);
    assign w_commit    = (r_state == ST_DATA) && w_sample && !w_cs_fall &&
                         (r_cnt == 5'd23) && !r_rw && w_addr_ok;

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (w_shift_nxt[6:0] == 7'(k))
                w_rd_data = r_regs[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 5'd0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_addr    <= 7'd0;
            r_tx      <= 16'h0000;
            r_sdo     <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (w_cs_fall) begin
                r_state <= ST_CMD;
                r_cnt   <= 5'd0;
                r_shift <= '0;
                r_rw    <= 1'b0;
                r_addr  <= 7'd0;
                r_tx    <= 16'h0000;
                r_sdo   <= 1'b1;
            end else if (w_cs_rise) begin
                if (r_state != ST_IDLE) begin
                    r_state   <= ST_IDLE;
                    frame_err <= (r_cnt != 5'd24);
                end
                r_cnt <= 5'd0;
            end else begin
                case (r_state)
                    ST_CMD: begin
                        if (w_sample) begin
                            r_shift <= w_shift_nxt[12:0];
                            r_cnt   <= r_cnt + 5'd1;
                            if (r_cnt == 5'd7) begin
                                r_state <= ST_DATA;
                                r_rw    <= w_shift_nxt[7];
                                r_addr  <= w_shift_nxt[6:0];
                                r_tx    <= w_shift_nxt[7] ? {2'b00, w_rd_data} : 16'h0000;
                                r_sdo   <= 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sample) begin
                            r_shift <= w_shift_nxt[12:0];
                            r_cnt   <= r_cnt + 5'd1;
                            if (r_cnt == 5'd23)
                                r_state <= ST_HOLD;
                        end else if (w_sck_fall && r_rw) begin
                            r_sdo <= r_tx[15];
                            r_tx  <= {r_tx[14:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_REGS; k++)
                r_regs[k] <= REG_INIT;
            wr_stb  <= 1'b0;
            wr_addr <= 7'd0;
            wr_data <= 14'h0000;
        end else begin
            wr_stb <= w_commit;
            if (w_commit) begin
                wr_addr <= r_addr;
                wr_data <= w_shift_nxt[13:0];
                for (int k = 0; k < N_REGS; k++) begin
                    if (r_addr == 7'(k))
                        r_regs[k] <= w_shift_nxt[13:0];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_REGS; g++) begin : g_regs_out
            assign regs[14*g +: 14] = r_regs[g];
        end
    endgenerate

    assign busy   = (r_state != ST_IDLE);
    assign sdatao = (r_state == ST_DATA && r_rw) ? r_sdo : 1'b1;

endmodule

// File: tb/tb_bos_spi_slave.sv
// Randomised SPI master with a register-file reference model; monitors score write
// strobes, frame errors and MISO read data against queued expectations.
module tb_bos_spi_slave;

    localparam int N_REGS = 8;
    localparam int HALF   = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 sck = 1'b1;
    logic                 sdatai = 1'b0;
    logic                 n_cs = 1'b1;
    logic                 sdatao;
    logic [14*N_REGS-1:0] regs;
    logic                 wr_stb;
    logic [6:0]           wr_addr;
    logic [13:0]          wr_data;
    logic                 frame_err;
    logic                 busy;

    bos_spi_slave #(.N_REGS(N_REGS), .REG_INIT(14'h0000)) dut (
        .clk(clk), .rst(rst), .sck(sck), .sdatai(sdatai), .n_cs(n_cs),
        .sdatao(sdatao), .regs(regs), .wr_stb(wr_stb), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  a;
        logic [13:0] d;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] model [N_REGS];
    wr_t         exp_wr [$];
    logic [15:0] exp_rd [$];
    int          exp_err [$];
    int          n_stb = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < N_REGS; k++)
            chk($sformatf("%s reg%0d", tag, k), 32'(regs[14*k +: 14]), 32'(model[k]));
    endtask

    // write-strobe / frame-error monitor
    wr_t m_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_stb) begin
                n_stb++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected wr_stb", 1, 0);
                end else begin
                    m_e = exp_wr.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(m_e.a));
                    chk("wr_data", 32'(wr_data), 32'(m_e.d));
                    chk("reg after write", 32'(regs[14*m_e.a +: 14]), 32'(m_e.d));
                end
            end
            if (frame_err) begin
                n_err++;
                if (exp_err.size() == 0) chk("unexpected frame_err", 1, 0);
                else void'(exp_err.pop_front());
            end
        end
    end

    // MISO monitor: samples sdatao on sck rising edges like the master does
    int          mcnt;
    logic [15:0] mrd;
    logic        mrw;
    logic        idle_ok;
    initial begin
        forever begin
            @(negedge n_cs);
            mcnt = 0; mrd = 16'h0; mrw = 1'b0; idle_ok = 1'b1;
            while (n_cs === 1'b0) begin
                @(posedge sck or posedge n_cs);
                if (n_cs === 1'b0 && sck === 1'b1) begin
                    mcnt++;
                    if (mcnt == 1) mrw = sdatai;
                    if (mcnt <= 8) begin
                        if (sdatao !== 1'b1) idle_ok = 1'b0;
                    end else if (mcnt <= 24) begin
                        if (mrw) mrd = {mrd[14:0], sdatao};
                        else if (sdatao !== 1'b1) idle_ok = 1'b0;
                    end
                end
            end
            if (mcnt == 24) begin
                chk("sdatao high outside read data", 32'(idle_ok), 1);
                if (mrw) begin
                    if (exp_rd.size() == 0) chk("unexpected read", 1, 0);
                    else chk("read data", 32'(mrd), 32'(exp_rd.pop_front()));
                end
            end
            wait_clk(4);
            chk("sdatao after n_cs high", 32'(sdatao), 1);
        end
    end

    task automatic check_reset_outputs();
        chk("rst sdatao", 32'(sdatao), 1);
        chk("rst busy", 32'(busy), 0);
        chk("rst wr_stb", 32'(wr_stb), 0);
        chk("rst frame_err", 32'(frame_err), 0);
        chk("rst wr_addr", 32'(wr_addr), 0);
        chk("rst wr_data", 32'(wr_data), 0);
        check_regs("rst");
    endtask

    // One frame; rst_at > 0 asserts reset after that many bits and abandons the frame.
    task automatic spi_frame(input logic [23:0] f, input int nbits, input int gap, input int rst_at);
        int ai;
        ai = int'(f[22:16]);
        if (rst_at <= 0) begin
            if (nbits == 24) begin
                if (!f[23]) begin
                    if (ai < N_REGS) begin
                        model[ai] = f[13:0];
                        exp_wr.push_back({f[22:16], f[13:0]});
                    end
                end else begin
                    exp_rd.push_back(ai < N_REGS ? {2'b00, model[ai]} : 16'h0000);
                end
            end else begin
                exp_err.push_back(1);
            end
        end
        n_cs = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b0;
            sdatai = f[23-i];
            wait_clk(HALF);
            sck = 1'b1;
            wait_clk(HALF);
            if (i + 1 == rst_at) begin
                rst = 1'b1;
                wait_clk(3);
                for (int k = 0; k < N_REGS; k++) model[k] = 14'h0000;
                check_reset_outputs();
                rst = 1'b0;
                wait_clk(4);
                for (int j = 0; j < 4; j++) begin
                    sck = 1'b0; sdatai = ~sdatai;
                    wait_clk(HALF);
                    sck = 1'b1;
                    wait_clk(HALF);
                end
                break;
            end
        end
        n_cs = 1'b1;
        wait_clk(gap);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0;
        logic [23:0] f;
        for (int k = 0; k < N_REGS; k++) model[k] = 14'h0000;
        rst = 1'b1;
        wait_clk(5);
        check_reset_outputs();
        rst = 1'b0;
        wait_clk(10);

        spi_frame(24'h030F00, 24, 20, 0);
        check_regs("write 3");
        spi_frame(24'h830000, 24, 20, 0);

        spi_frame(24'h090123, 24, 20, 0);
        spi_frame(24'h890000, 24, 20, 0);
        check_regs("write oob");

        spi_frame({20'h03FFF, 4'h0}, 20, 20, 0);
        check_regs("short frame");
        spi_frame(24'h030001, 24, 20, 0);
        check_regs("after short");

        spi_frame(24'h031234, 24, 20, 12);
        chk("post-reset busy", 32'(busy), 0);
        spi_frame(24'h030ABC, 24, 20, 0);
        check_regs("after reset");

        s0 = n_stb; e0 = n_err;
        for (int i = 0; i < 10; i++) spi_frame(24'h030F00, 24, 7, 0);
        wait_clk(10);
        chk("back-to-back wr_stb count", 32'(n_stb - s0), 10);
        chk("back-to-back frame_err count", 32'(n_err - e0), 0);

        for (int i = 0; i < 30; i++) begin
            f[23]    = 1'($urandom_range(0, 1));
            f[22:16] = 7'($urandom_range(0, 11));
            f[15:0]  = 16'($urandom);
            spi_frame(f, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 23) : 24,
                      $urandom_range(7, 20), 0);
        end
        wait_clk(20);
        check_regs("random");
        chk("pending writes", 32'(exp_wr.size()), 0);
        chk("pending reads", 32'(exp_rd.size()), 0);
        chk("pending frame_err", 32'(exp_err.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bos_spi_slave.md
BOS_SPI_SLAVE -- requirements
Module: bos_spi_slave

Interface
REQ-001 Parameters SHALL be, one per line:
- N_REGS, 8, number of 14-bit registers implemented, addresses 0..N_REGS-1.
- REG_INIT, 14'h0000, reset value of every register.
REQ-002 Ports SHALL be, one per line:
- clk, in, 1, system clock, sole clock domain.
- rst, in, 1, asynchronous active-high reset.
- sck, in, 1, SPI clock (CPOL=1, CPHA=1), asynchronous to clk.
- sdatai, in, 1, SPI MOSI, asynchronous.
- n_cs, in, 1, active-low chip select (one sl line), asynchronous.
- sdatao, out, 1, SPI MISO.
- regs, out, 14*N_REGS, register file; reg k at bits [14k+13:14k].
- wr_stb, out, 1, one-cycle pulse on committed write.
- wr_addr, out, 7, address of last committed write.
- wr_data, out, 14, data of last committed write.
- frame_err, out, 1, one-cycle pulse on malformed frame.
- busy, out, 1, high while a frame is in progress.
REQ-003 Clock is clk only; reset is asynchronous active-high on rst.

Function
REQ-004 sck, sdatai and n_cs SHALL each pass a 2-flop synchronizer; edges SHALL be detected on the synchronized copies; sck half-period ≥ 4 clk is a supported-range requirement.
REQ-005 Frame SHALL be 24 bits MSB first: bit23 R/W (0=write, 1=read), bits22:16 address, bits15:14 rfu (ignored), bits13:0 data.
REQ-006 sdatai SHALL be sampled on synchronized sck rising edges only while synchronized n_cs is low; a 5-bit bit counter SHALL count sampled bits.
REQ-007 FSM states: IDLE, CMD, DATA, HOLD.
- IDLE→CMD on n_cs falling edge; clear counter and shift register.
- CMD→DATA after 8th rising edge; latch R/W and address.
- DATA→HOLD after 24th rising edge.
- HOLD→IDLE on n_cs rising edge.
- Any state except IDLE → IDLE on n_cs rising edge.
REQ-008 busy SHALL be high in CMD, DATA, HOLD.
REQ-009 Write commit: in the cycle the 24th bit is sampled, if R/W=0 and address < N_REGS, the addressed register SHALL take bits13:0 on the next clk edge, and wr_stb, wr_addr, wr_data SHALL update on that same edge.
REQ-010 Writes to address ≥ N_REGS SHALL be discarded with no wr_stb and no frame_err.
REQ-011 Read: on the 8th rising edge with R/W=1, a 16-bit output shift register SHALL load {2'b00, reg[addr]} (16'h0000 if addr ≥ N_REGS).
- sdatao SHALL present its MSB on each synchronized sck falling edge in DATA, then shift left.
- This yields bits 15..0 sampled by the master on rising edges 9..24.
REQ-012 sdatao SHALL be 1 in IDLE, CMD, HOLD and during write frames.
REQ-013 Bits beyond 24 SHALL be ignored in HOLD; no second commit.
REQ-014 n_cs rising edge with count ≠ 24: frame_err SHALL pulse one cycle; no register change.
REQ-015 sck rising edge and n_cs rising edge detected in the same cycle: n_cs SHALL win; the bit SHALL NOT be counted.
REQ-016 n_cs falling edge while not IDLE cannot occur; if the synchronizer reports it, the frame SHALL restart in CMD without frame_err.

Reset
REQ-017 While rst is high, the following SHALL hold:
- FSM = IDLE, counter = 0.
- sdatao = 1, busy = 0, wr_stb = 0, frame_err = 0.
- wr_addr = 0, wr_data = 0, all regs = REG_INIT, synchronizers = idle levels (sck=1, n_cs=1, sdatai=0).
REQ-018 Reset asserted mid-frame SHALL abort the frame without commit; after release, the first frame SHALL start only on a fresh n_cs falling edge.

Verification
REQ-019 Write 24'h030F00, sck half-period 8 clk → one wr_stb, wr_addr=3, wr_data=14'h0F00, regs[3]=14'h0F00, other regs unchanged.
REQ-020 After REQ-019, read 24'h830000 → master captures 16'h0F00 on sdatao; sdatao=1 before rising edge 9 and after n_cs high.
REQ-021 Write 24'h090123 with N_REGS=8 → no wr_stb, no frame_err, regs unchanged; read of address 9 returns 16'h0000.
REQ-022 20-bit frame 0x03FFF then n_cs high → frame_err pulse, no wr_stb, regs[3] unchanged; a following full write of 24'h030001 → regs[3]=14'h0001.
REQ-023 Assert rst after 12 bits of 24'h031234 → all outputs at reset values; a subsequent complete frame 24'h030ABC → regs[3]=14'h0ABC.
REQ-024 Ten back-to-back writes with 7-clk n_cs gaps (ten frames of 24'h030F00) → exactly ten wr_stb pulses, no frame_err.
